// File: rtl/pwm_capture.sv
// PWM capture: measures period (rise to rise) and high time (rise to fall) of an
// asynchronous input in clk cycles, with a valid/ready result port, sticky overrun,
// and stuck-input timeout detection.
module pwm_capture #(
  parameter int unsigned CNT_WIDTH   = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = (1 << CNT_WIDTH) - 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pwm_in,
  input  logic                 enable,
  output logic [CNT_WIDTH-1:0] period_o,
  output logic [CNT_WIDTH-1:0] high_o,
  output logic                 meas_valid,
  input  logic                 meas_ready,
  output logic                 overrun,
  output logic                 timeout,
  output logic                 stuck_level
);

  localparam logic [CNT_WIDTH-1:0] CntOne     = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CntMax     = '1;
  localparam logic [CNT_WIDTH-1:0] TimeoutCnt = CNT_WIDTH'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StArm, StHigh, StLow} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]   high_r_q, high_r_d;
  logic [CNT_WIDTH-1:0]   period_q, period_d;
  logic [CNT_WIDTH-1:0]   high_q, high_d;
  logic                   valid_q, valid_d;
  logic                   overrun_q, overrun_d;
  logic                   timeout_q, timeout_d;
  logic                   stuck_q, stuck_d;

  logic                   sync, rise, fall, stuck_hit, publish, accept;
  logic [CNT_WIDTH-1:0]   cnt_inc;

  assign sync_d  = {sync_q[SYNC_STAGES-2:0], pwm_in};
  assign sync    = sync_q[SYNC_STAGES-1];
  assign rise    = sync & ~hist_q;
  assign fall    = ~sync & hist_q;
  assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;
  // >= rather than == so an ignored edge landing exactly on the limit cannot
  // push the counter past it and silence stuck detection for good.
  assign stuck_hit = enable && (state_q != StIdle) && !(rise || fall) && (cnt_q >= TimeoutCnt);
  assign publish   = enable && (state_q == StLow) && rise;
  assign accept    = valid_q && meas_ready;

  // Synchronizer, edge history and all registered state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      sync_q    <= '0;
      hist_q    <= 1'b0;
      cnt_q     <= '0;
      high_r_q  <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
      stuck_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      hist_q    <= sync;
      cnt_q     <= cnt_d;
      high_r_q  <= high_r_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
      stuck_q   <= stuck_d;
    end
  end

  // Next-state: edges take precedence over the stuck timeout.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:  state_d = StArm;
        StArm:   if (rise) state_d = StHigh;
        StHigh:  if (fall) state_d = StLow;  else if (stuck_hit) state_d = StArm;
        StLow:   if (rise) state_d = StHigh; else if (stuck_hit) state_d = StArm;
        default: state_d = StIdle;
      endcase
    end
  end

  // Counter, measurement latches, result handshake and timeout outputs.
  always_comb begin
    cnt_d     = cnt_q;
    high_r_d  = high_r_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    timeout_d = 1'b0;
    stuck_d   = stuck_q;
    if (!enable) begin
      cnt_d     = '0;
      period_d  = '0;
      high_d    = '0;
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end else begin
      case (state_q)
        StIdle:  cnt_d = CntOne;
        StArm:   cnt_d = (rise || stuck_hit) ? CntOne : cnt_inc;
        StHigh: begin
          if (fall) high_r_d = cnt_q;
          cnt_d = stuck_hit ? CntOne : cnt_inc;
        end
        StLow:   cnt_d = (rise || stuck_hit) ? CntOne : cnt_inc;
        default: cnt_d = '0;
      endcase
      if (stuck_hit) begin
        timeout_d = 1'b1;
        stuck_d   = sync;
      end
      if (publish) begin
        period_d = cnt_q;
        high_d   = high_r_q;
        valid_d  = 1'b1;
        if (valid_q && !meas_ready) overrun_d = 1'b1;
      end else if (accept) begin
        valid_d = 1'b0;
      end
    end
  end

  assign period_o    = period_q;
  assign high_o      = high_q;
  assign meas_valid  = valid_q;
  assign overrun     = overrun_q;
  assign timeout     = timeout_q;
  assign stuck_level = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: drives waveforms built from high/low segments and
// compares every cycle against a timestamp-based model of the measurement rules.
module tb_pwm_capture;

  localparam int CW   = 16;
  localparam int S    = 2;
  localparam int TO   = 200;
  localparam int LMAX = 16384;

  logic          clk = 1'b0;
  logic          rst_n, pwm_in, enable, meas_ready;
  logic [CW-1:0] period_o, high_o;
  logic          meas_valid, overrun, timeout, stuck_level;

  pwm_capture #(.CNT_WIDTH(CW), .SYNC_STAGES(S), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pwm_in     (pwm_in),
    .enable     (enable),
    .period_o   (period_o),
    .high_o     (high_o),
    .meas_valid (meas_valid),
    .meas_ready (meas_ready),
    .overrun    (overrun),
    .timeout    (timeout),
    .stuck_level(stuck_level)
  );

  always #5 clk = ~clk;

  typedef struct {bit lv; int n;} seg_t;
  seg_t seg_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 10;
  int rdy_cfg  = 1;  // 0: low, 1: high, 2: random, 3: high only at edge rdy_at
  int rdy_at   = 0;
  bit lvl [LMAX];    // pwm_in as sampled at each clock edge

  // Reference model state: timestamps are detection cycles on the input timeline.
  bit            m_active, m_have_rise, m_have_fall;
  int            m_rise_t, m_fall_t, m_load_t;
  bit            ex_valid, ex_over, ex_to, ex_stuck;
  logic [CW-1:0] ex_per, ex_high;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic model_clear();
    m_active = 0; m_have_rise = 0; m_have_fall = 0;
    ex_valid = 0; ex_over = 0; ex_to = 0; ex_stuck = 0; ex_per = '0; ex_high = '0;
  endtask

  // Applies the effect of the clock edge 'cyc' given inputs present at that edge.
  task automatic model_step();
    int td;
    bit s, h, rise, fall, pub, to;
    logic [CW-1:0] p_per, p_high;
    td = cyc - 1;
    s = lvl[td-S+1];
    h = lvl[td-S];
    rise = s && !h;
    fall = !s && h;
    pub = 0; to = 0; p_per = '0; p_high = '0;
    if (m_active && enable) begin
      if (rise) begin
        if (m_have_rise && m_have_fall) begin
          pub = 1;
          p_per  = CW'(td - m_rise_t);
          p_high = CW'(m_fall_t - m_rise_t);
        end
        m_have_rise = 1; m_have_fall = 0; m_rise_t = td; m_load_t = td;
      end else if (fall) begin
        if (m_have_rise) begin m_have_fall = 1; m_fall_t = td; end
      end else if (td - m_load_t == TO) begin
        to = 1; m_have_rise = 0; m_have_fall = 0; m_load_t = td;
      end
    end
    if (!enable) begin
      m_active = 0; m_have_rise = 0; m_have_fall = 0;
      ex_valid = 0; ex_over = 0; ex_per = '0; ex_high = '0; ex_to = 0;
    end else begin
      if (!m_active) begin m_active = 1; m_load_t = td; end
      ex_to = to;
      if (to) ex_stuck = s;
      if (pub) begin
        if (ex_valid && !meas_ready) ex_over = 1;
        ex_valid = 1; ex_per = p_per; ex_high = p_high;
      end else if (ex_valid && meas_ready) begin
        ex_valid = 0;
      end
    end
  endtask

  task automatic tick();
    seg_t sg;
    @(posedge clk);
    #1;
    cyc++;
    if (cyc + 2 >= LMAX) begin
      $display("FAIL cycle_budget: got %0d, expected below %0d", cyc, LMAX);
      $fatal(1, "cycle budget exhausted");
    end
    model_step();
    check("valid",   meas_valid,  ex_valid);
    check("overrun", overrun,     ex_over);
    check("period",  period_o,    ex_per);
    check("high",    high_o,      ex_high);
    check("timeout", timeout,     ex_to);
    check("stuck",   stuck_level, ex_stuck);
    if (seg_q.size() > 0) begin
      sg = seg_q.pop_front();
      pwm_in = sg.lv;
      sg.n--;
      if (sg.n > 0) seg_q.push_front(sg);
    end
    case (rdy_cfg)
      0:       meas_ready = 1'b0;
      1:       meas_ready = 1'b1;
      2:       meas_ready = 1'($urandom_range(0, 1));
      default: meas_ready = (cyc + 1 == rdy_at);
    endcase
    lvl[cyc+1] = pwm_in;
  endtask

  task automatic push(input bit lv, input int n);
    seg_t sg;
    sg.lv = lv; sg.n = n;
    seg_q.push_back(sg);
  endtask

  task automatic run_segs(input int tail);
    while (seg_q.size() > 0) tick();
    repeat (tail) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; pwm_in = 1'b0; enable = 1'b1;
    seg_q.delete();
    #1;
    check("rst_period",  period_o,    0);
    check("rst_high",    high_o,      0);
    check("rst_valid",   meas_valid,  0);
    check("rst_overrun", overrun,     0);
    check("rst_timeout", timeout,     0);
    check("rst_stuck",   stuck_level, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      cyc++;
      lvl[cyc] = 1'b0;
    end
    lvl[cyc+1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  initial begin
    int cnt, last_to, base;
    rst_n = 1'b0; pwm_in = 1'b0; enable = 1'b1; meas_ready = 1'b0;
    model_clear();

    // 30 high / 70 low with ready held high: one valid cycle per period.
    do_reset();
    rdy_cfg = 1;
    push(0, 10);
    repeat (4) begin push(1, 30); push(0, 70); end
    cnt = 0;
    while (seg_q.size() > 0) begin tick(); if (meas_valid) cnt++; end
    repeat (5) begin tick(); if (meas_valid) cnt++; end
    check("b_nvalid", cnt, 3);
    check("b_period", period_o, 100);
    check("b_high",   high_o,   30);

    // Same waveform, consumer stalled: overrun with latest data, then one accept.
    do_reset();
    rdy_cfg = 0;
    push(0, 10);
    repeat (5) begin push(1, 30); push(0, 70); end
    run_segs(5);
    check("c_overrun", overrun,    1);
    check("c_valid",   meas_valid, 1);
    check("c_period",  period_o,   100);
    rdy_cfg = 1;
    tick();
    rdy_cfg = 0;
    tick();
    check("c_valid_after_accept", meas_valid, 0);
    check("c_period_hold",        period_o,   100);

    // Publication coinciding with an accept keeps valid and leaves overrun clear.
    do_reset();
    rdy_cfg = 0;
    base = cyc + 2;
    push(0, 10);
    repeat (3) begin push(1, 30); push(0, 70); end
    rdy_at = base + 210 + S;
    rdy_cfg = 3;
    while (cyc < rdy_at) tick();
    check("f_valid",   meas_valid, 1);
    check("f_overrun", overrun,    0);
    check("f_period",  period_o,   100);
    run_segs(5);

    // Random widths and random consumer back-pressure.
    do_reset();
    rdy_cfg = 2;
    push(0, 10);
    repeat (40) begin
      push(1, int'($urandom_range(1, 40)));
      push(0, int'($urandom_range(1, 40)));
    end
    run_segs(5);

    // Enable dropped in the middle of a high phase, then restored.
    do_reset();
    rdy_cfg = 1;
    push(0, 10);
    repeat (2) begin push(1, 20); push(0, 20); end
    push(1, 60); push(0, 20);
    repeat (3) begin push(1, 20); push(0, 20); end
    repeat (120) tick();
    enable = 1'b0;
    tick();
    check("e_valid_off",  meas_valid, 0);
    check("e_period_off", period_o,   0);
    check("e_high_off",   high_o,     0);
    tick(); tick();
    enable = 1'b1;
    cnt = 0;
    while (seg_q.size() > 0) begin tick(); if (meas_valid) cnt++; end
    repeat (5) begin tick(); if (meas_valid) cnt++; end
    check("e_npub", cnt, 2);

    // Input stuck high after a rise: periodic timeout pulses, no results.
    do_reset();
    rdy_cfg = 1;
    push(0, 10); push(1, 700); push(0, 50);
    cnt = 0; last_to = 0;
    while (seg_q.size() > 0 || cyc < 0) begin
      tick();
      if (timeout) begin
        if (cnt > 0) check("g_gap", cyc - last_to, TO);
        cnt++;
        last_to = cyc;
      end
      if (meas_valid) check("g_novalid", meas_valid, 0);
    end
    check("g_npulse", cnt, 3);
    check("g_stuck",  stuck_level, 1);

    // Reset asserted mid-low: outputs clear at once, two rises needed afterwards.
    do_reset();
    rdy_cfg = 1;
    push(0, 10);
    repeat (2) begin push(1, 20); push(0, 60); end
    repeat (140) tick();
    do_reset();
    push(0, 10);
    repeat (3) begin push(1, 20); push(0, 20); end
    cnt = 0;
    while (seg_q.size() > 0) begin tick(); if (meas_valid) cnt++; end
    repeat (5) begin tick(); if (meas_valid) cnt++; end
    check("h_npub", cnt, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
